// File: rtl/dram_sched_pkg.sv
// Shared types and constants for the L2-to-DRAM write-buffering scheduler.
package dram_sched_pkg;

  localparam int BLK_OFF_BITS = 4;
  localparam int TAG_W        = 28;
  localparam int BLK_W        = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_MEM = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [BLK_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_buffer.sv
// Circular write-back FIFO with a parallel tag CAM and an in-place data update port.
// Optional hit_data output exists only when DRAM_SCHED_FWD_EN is defined.
module wb_buffer
  import dram_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [TAG_W-1:0]          push_tag,
  input  logic [BLK_W-1:0]          push_data,
  input  logic                      pop,
  input  logic                      upd,
  input  logic [$clog2(DEPTH)-1:0]  upd_idx,
  input  logic [BLK_W-1:0]          upd_data,
  input  logic [TAG_W-1:0]          lookup_tag,
  output logic                      hit,
  output logic [$clog2(DEPTH)-1:0]  hit_idx,
`ifdef DRAM_SCHED_FWD_EN
  output logic [BLK_W-1:0]          hit_data,
`endif
  output logic [TAG_W-1:0]          head_tag,
  output logic [BLK_W-1:0]          head_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  wb_entry_t          entry_r [DEPTH];
  logic [DEPTH-1:0]   valid_r;
  logic [IDX_W-1:0]   head_r;
  logic [IDX_W-1:0]   tail_r;
  logic [CNT_W-1:0]   count_r;
  logic [DEPTH-1:0]   match_s;
  logic [IDX_W-1:0]   hit_idx_s;

  // Tag CAM: tags are unique, so OR-ing the matching indices yields the hit index.
  always_comb begin
    match_s   = '0;
    hit_idx_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = valid_r[i] && (entry_r[i].tag == lookup_tag);
      hit_idx_s  = hit_idx_s | (match_s[i] ? i[IDX_W-1:0] : {IDX_W{1'b0}});
    end
  end

  assign hit       = |match_s;
  assign hit_idx   = hit_idx_s;
`ifdef DRAM_SCHED_FWD_EN
  assign hit_data  = entry_r[hit_idx_s].data;
`endif
  assign head_tag  = entry_r[head_r].tag;
  assign head_data = entry_r[head_r].data;
  assign count     = count_r;
  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});

  // Pointer, occupancy and valid-bit bookkeeping; push and pop are mutually exclusive.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      valid_r <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          valid_r[tail_r] <= 1'b1;
          tail_r          <= tail_r + IDX_W'(1'b1);
          count_r         <= count_r + CNT_W'(1'b1);
        end
        2'b01: begin
          valid_r[head_r] <= 1'b0;
          head_r          <= head_r + IDX_W'(1'b1);
          count_r         <= count_r - CNT_W'(1'b1);
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  // Entry storage; contents need no reset because valid bits gate every use.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_r[tail_r].tag  <= push_tag;
      entry_r[tail_r].data <= push_data;
    end
    if (upd) begin
      entry_r[upd_idx].data <= upd_data;
    end
  end

endmodule

// File: rtl/dram_sched.sv
// Scheduler between the L2 DRAM port and DRAM: posted/coalesced writes, read priority, FIFO drain.
// Define DRAM_SCHED_FWD_EN to return read hits straight from the write buffer.
module dram_sched
  import dram_sched_pkg::*;
#(
  parameter int WB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        l2_valid,
  input  logic                        l2_write,
  input  logic [31:0]                 l2_addr,
  input  logic [127:0]                l2_wdata,
  output logic [127:0]                l2_rdata,
  output logic                        l2_ready,
  output logic                        mem_valid,
  output logic                        mem_write,
  output logic [31:0]                 mem_addr,
  output logic [127:0]                mem_wdata,
  input  logic [127:0]                mem_rdata,
  input  logic                        mem_ready,
  output logic [$clog2(WB_DEPTH):0]   wb_count
);

  localparam int IDX_W = $clog2(WB_DEPTH);

  state_t             state_r;
  state_t             state_next_s;
  logic [TAG_W-1:0]   req_tag_s;
  logic               push_s;
  logic               pop_s;
  logic               upd_s;
  logic               hit_s;
  logic [IDX_W-1:0]   hit_idx_s;
  logic [TAG_W-1:0]   head_tag_s;
  logic [BLK_W-1:0]   head_data_s;
  logic               full_s;
  logic               empty_s;
  logic [BLK_W-1:0]   rdata_next_s;
  logic               unused_addr_s;
`ifdef DRAM_SCHED_FWD_EN
  logic [BLK_W-1:0]   hit_data_s;
`endif

  assign req_tag_s     = l2_addr[31:BLK_OFF_BITS];
  assign unused_addr_s = ^l2_addr[BLK_OFF_BITS-1:0];

  wb_buffer #(.DEPTH(WB_DEPTH)) u_wb (
    .clk        (clk),
    .reset      (reset),
    .push       (push_s),
    .push_tag   (req_tag_s),
    .push_data  (l2_wdata),
    .pop        (pop_s),
    .upd        (upd_s),
    .upd_idx    (hit_idx_s),
    .upd_data   (l2_wdata),
    .lookup_tag (req_tag_s),
    .hit        (hit_s),
    .hit_idx    (hit_idx_s),
`ifdef DRAM_SCHED_FWD_EN
    .hit_data   (hit_data_s),
`endif
    .head_tag   (head_tag_s),
    .head_data  (head_data_s),
    .full       (full_s),
    .empty      (empty_s),
    .count      (wb_count)
  );

  // Next-state and buffer-control decode; IDLE applies the request priority order.
  always_comb begin
    state_next_s = state_r;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    upd_s        = 1'b0;
    rdata_next_s = l2_rdata;
    case (state_r)
      IDLE: begin
        if (l2_valid && !l2_write && hit_s) begin
`ifdef DRAM_SCHED_FWD_EN
          rdata_next_s = hit_data_s;
          state_next_s = RESP;
`else
          // Keep draining until the matching tag has left the buffer.
          state_next_s = DRAIN;
`endif
        end else if (l2_valid && !l2_write) begin
          state_next_s = RD_MEM;
        end else if (l2_valid && hit_s) begin
          upd_s        = 1'b1;
          state_next_s = RESP;
        end else if (l2_valid && !full_s) begin
          push_s       = 1'b1;
          state_next_s = RESP;
        end else if (l2_valid || !empty_s) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RD_MEM: begin
        if (mem_ready) begin
          rdata_next_s = mem_rdata;
          state_next_s = RESP;
        end else begin
          state_next_s = RD_MEM;
        end
      end
      DRAIN: begin
        if (mem_ready) begin
          pop_s        = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      RESP: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register and registered outputs, all derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      l2_ready  <= 1'b0;
      l2_rdata  <= '0;
      mem_valid <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_r   <= state_next_s;
      l2_ready  <= (state_next_s == RESP);
      l2_rdata  <= rdata_next_s;
      mem_valid <= (state_next_s == RD_MEM) || (state_next_s == DRAIN);
      if (state_next_s == RD_MEM) begin
        mem_write <= 1'b0;
        mem_addr  <= {req_tag_s, {BLK_OFF_BITS{1'b0}}};
      end else if (state_next_s == DRAIN) begin
        mem_write <= 1'b1;
        mem_addr  <= {head_tag_s, {BLK_OFF_BITS{1'b0}}};
        mem_wdata <= head_data_s;
      end
    end
  end

endmodule
